// File: rtl/uart_tx_buffered_pkg.sv
// UART_pkg: shared UART byte type, transmitter FSM states and parity helper
package UART_pkg;

    typedef logic [7:0] uart_data_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    function automatic logic parity_bit(input uart_data_t d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// uart_fifo: power-of-two byte FIFO with registered occupancy and full/empty flags
module uart_fifo
    import UART_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  uart_data_t    wr_data_i,
    input  logic          rd_en_i,
    output uart_data_t    rd_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    uart_data_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push, pop;

    // Acceptance uses the registered full flag only, so a same-cycle pop never frees room.
    assign push      = wr_en_i & ~full_o;
    assign pop       = rd_en_i & ~empty_o;
    assign full_o    = level_q == LW'(DEPTH);
    assign empty_o   = level_q == '0;
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are meaningless while level is zero.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter with optional parity and back-to-back frames
module uart_tx_buffered
    import UART_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  uart_data_t    wr_data,
    input  logic          wr_en,
    output logic          tx,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          busy,
    output logic          overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    uart_tx_state_e state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    uart_data_t     data_q, data_d, head;
    logic           tx_q, tx_d, busy_q, overflow_q, pop, last;

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (full),
        .empty_o   (empty),
        .level_o   (level)
    );

    assign last     = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

    // Frame sequencing: pop on entry to START, from IDLE or straight out of STOP.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        data_d  = data_q;
        pop     = 1'b0;
        cnt_d   = (state_q == IDLE || last) ? '0 : cnt_q + CW'(1);
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    data_d  = head;
                    state_d = START;
                end
            end
            START: begin
                if (last) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (last) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (last) state_d = STOP;
            end
            STOP: begin
                if (last) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        data_d  = head;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level for the current state, registered one cycle behind the state.
    always_comb begin
        tx_d = state_q == START  ? 1'b0 :
               state_q == DATA   ? data_q[bit_q] :
               state_q == PARITY ? parity_bit(data_q, PARITY_ODD != 0) : 1'b1;
    end

    // State, counters, line and status registers; reset idles the line immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            tx_q       <= tx_d;
            busy_q     <= state_q != IDLE;
            overflow_q <= wr_en & full;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed checks of framing, buffering, overflow and reset
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data, wr_data2;
    logic       wr_en, wr_en2;
    logic       tx, full, empty, busy, overflow;
    logic       tx2, full2, empty2, busy2, ovf2;
    logic [3:0] level, level2;
    int         vectors = 0;
    int         errs = 0;

    logic [7:0] bb [9] = '{8'h01, 8'h02, 8'h03, 8'h80, 8'hFF, 8'h7E, 8'h11, 8'hE0, 8'h99};
    logic       pp [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [10:0] fb0;

    uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .tx(tx), .full(full),
        .empty(empty), .level(level), .busy(busy), .overflow(overflow)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .wr_data(wr_data2), .wr_en(wr_en2), .tx(tx2), .full(full2),
        .empty(empty2), .level(level2), .busy(busy2), .overflow(ovf2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_frame(input bit odd, input logic [7:0] d, input logic p, input int start);
        logic [10:0] fb;
        fb = {1'b1, p, d, 1'b0};
        for (int c = start; c < 44; c++) begin
            @(negedge clk);
            chk("frame_tx", 8'(odd ? tx2 : tx), 8'(fb[4'(c / 4)]));
            chk("frame_busy", 8'(odd ? busy2 : busy), 8'd1);
        end
    endtask

    task automatic check_idle;
        @(negedge clk);
        chk("idle_tx", 8'(tx), 8'd1);
        chk("idle_busy", 8'(busy), 8'd0);
        chk("idle_empty", 8'(empty), 8'd1);
        chk("idle_level", 8'(level), 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'hEE;
        wr_en2 = 1'b0;
        wr_data2 = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", 8'(tx), 8'd1);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_full", 8'(full), 8'd0);
        chk("rst_empty", 8'(empty), 8'd1);
        chk("rst_level", 8'(level), 8'd0);
        chk("rst_ovf", 8'(overflow), 8'd0);

        rst = 1'b0;
        wr_data = 8'h55;
        @(negedge clk);
        wr_en = 1'b0;
        chk("w55_level", 8'(level), 8'd1);
        chk("w55_empty", 8'(empty), 8'd0);
        @(negedge clk);
        chk("w55_tx_lat", 8'(tx), 8'd1);
        chk("w55_busy_lat", 8'(busy), 8'd0);
        check_frame(0, 8'h55, 1'b0, 0);
        check_idle();

        wr_en2 = 1'b1;
        wr_data2 = 8'h00;
        @(negedge clk);
        wr_en2 = 1'b0;
        @(negedge clk);
        chk("odd_tx_lat", 8'(tx2), 8'd1);
        check_frame(1, 8'h00, 1'b1, 0);
        @(negedge clk);
        chk("odd_stop_tx", 8'(tx2), 8'd1);
        chk("odd_busy", 8'(busy2), 8'd0);
        chk("odd_empty", 8'(empty2), 8'd1);

        wr_en = 1'b1;
        wr_data = 8'h3C;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        chk("burst_tx_lat", 8'(tx), 8'd1);
        fb0 = {1'b1, 1'b0, 8'h3C, 1'b0};
        for (int i = 0; i < 10; i++) begin
            wr_en = i < 9;
            wr_data = i < 9 ? bb[i] : 8'h00;
            @(negedge clk);
            chk("burst_level", 8'(level), 8'(i < 8 ? i + 1 : 8));
            chk("burst_ovf", 8'(overflow), 8'(i == 8));
            chk("burst_tx", 8'(tx), 8'(fb0[4'(i / 4)]));
        end
        wr_en = 1'b0;
        chk("burst_full", 8'(full), 8'd1);
        check_frame(0, 8'h3C, 1'b0, 10);
        for (int k = 0; k < 8; k++) check_frame(0, bb[k], pp[k], 0);
        check_idle();
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            chk("no_ninth_tx", 8'(tx), 8'd1);
        end

        wr_en = 1'b1;
        wr_data = 8'hA1;
        @(negedge clk);
        wr_data = 8'hB2;
        @(negedge clk);
        wr_data = 8'hC3;
        @(negedge clk);
        wr_en = 1'b0;
        chk("b2b_start", 8'(tx), 8'd0);
        chk("b2b_level", 8'(level), 8'd2);
        check_frame(0, 8'hA1, 1'b1, 1);
        check_frame(0, 8'hB2, 1'b0, 0);
        check_frame(0, 8'hC3, 1'b0, 0);
        check_idle();

        wr_en = 1'b1;
        wr_data = 8'h5A;
        @(negedge clk);
        chk("wp_level_a", 8'(level), 8'd1);
        wr_data = 8'h07;
        @(negedge clk);
        wr_en = 1'b0;
        chk("wp_level_b", 8'(level), 8'd1);
        chk("wp_tx_lat", 8'(tx), 8'd1);
        check_frame(0, 8'h5A, 1'b0, 0);
        check_frame(0, 8'h07, 1'b1, 0);
        check_idle();

        wr_en = 1'b1;
        wr_data = 8'h44;
        @(negedge clk);
        wr_data = 8'h45;
        @(negedge clk);
        wr_data = 8'h46;
        @(negedge clk);
        wr_data = 8'h47;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_level", 8'(level), 8'd3);
        chk("mid_busy", 8'(busy), 8'd1);
        chk("mid_tx", 8'(tx), 8'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_tx", 8'(tx), 8'd1);
        chk("async_level", 8'(level), 8'd0);
        chk("async_empty", 8'(empty), 8'd1);
        chk("async_busy", 8'(busy), 8'd0);
        chk("async_full", 8'(full), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("post_rst_tx", 8'(tx), 8'd1);
        end
        chk("post_rst_empty", 8'(empty), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
